// File: rtl/dec4to16_sync.sv
// dec4to16_sync: registered 4-to-16 one-hot decoder with enable and selectable output polarity.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; forces Y inactive and vld low
//   en   - decode enable, sampled on clk
//   A    - 4-bit select code, sampled on clk
//   Y    - registered decoded output, one cycle after (en, A)
//   vld  - registered copy of en, qualifies Y
// Parameter ACTIVE_LOW inverts the whole Y vector (selected line 0, others 1).

module dec3to8 (
   input  logic       en_i,
   input  logic [2:0] a_i,
   output logic [7:0] y_o
);
   // The ternary keeps the output at zero when disabled, even if a_i is unknown.
   always_comb y_o = en_i ? (8'h01 << a_i) : 8'h00;
endmodule

module dec4to16_sync #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  A,
   output logic [15:0] Y,
   output logic        vld
);
   localparam logic [15:0] INACTIVE = {16{ACTIVE_LOW}};
   logic [7:0]  lo, hi;
   logic [15:0] y_d, y_q;
   logic        vld_d, vld_q;
   // A[3] picks which 3-to-8 stage is enabled; the other stage stays all-zero.
   dec3to8 u_lo (.en_i(en & ~A[3]), .a_i(A[2:0]), .y_o(lo));
   dec3to8 u_hi (.en_i(en &  A[3]), .a_i(A[2:0]), .y_o(hi));
   always_comb begin
      y_d   = {hi, lo} ^ INACTIVE;
      vld_d = en;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q   <= INACTIVE;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         vld_q <= vld_d;
      end
   end
   assign Y   = y_q;
   assign vld = vld_q;
endmodule

// File: tb/tb_dec4to16_sync.sv
// tb_dec4to16_sync: self-checking bench for both polarities of dec4to16_sync against a reference model.
module tb_dec4to16_sync;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [3:0]  A   = 4'h0;
   logic [15:0] y0, y1;
   logic        v0, v1;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dec4to16_sync #(.ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .en(en), .A(A), .Y(y0), .vld(v0));
   dec4to16_sync #(.ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst(rst), .en(en), .A(A), .Y(y1), .vld(v1));

   // Reference: the selected line index equals the code value, active only when enabled and not in reset.
   function automatic logic [15:0] model(input logic r, input logic e, input logic [3:0] a);
      logic [15:0] m;
      m = 16'h0000;
      if (!r && e) m[a] = 1'b1;
      return m;
   endfunction

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Apply inputs, let one edge sample them, then check both instances 1 time unit later.
   task automatic step(input string tag, input logic r, input logic e, input logic [3:0] a);
      logic [15:0] m;
      rst = r;
      en  = e;
      A   = a;
      m   = model(r, e, a);
      @(posedge clk);
      #1;
      chk16({tag, " Y"}, y0, m);
      chk16({tag, " Ylow"}, y1, ~m);
      chk1({tag, " vld"}, v0, !r && e);
      chk1({tag, " vldlow"}, v1, !r && e);
   endtask

   initial begin
      logic r, e;
      logic [3:0] a;
      @(posedge clk);
      #1;
      step("reset1", 1'b1, 1'b1, 4'b0101);
      step("reset2", 1'b1, 1'b1, 4'b0101);
      step("reset_release", 1'b0, 1'b1, 4'b0101);
      chk16("reset_release_const", y0, 16'h0020);
      for (int i = 0; i < 16; i++) step("disabled", 1'b0, 1'b0, 4'(i));
      for (int i = 0; i < 16; i++) step("sweep", 1'b0, 1'b1, 4'(i));
      step("spot0", 1'b0, 1'b1, 4'd0);
      chk16("spot0_const", y0, 16'h0001);
      step("spot7", 1'b0, 1'b1, 4'd7);
      chk16("spot7_const", y0, 16'h0080);
      step("spot8", 1'b0, 1'b1, 4'd8);
      chk16("spot8_const", y0, 16'h0100);
      step("spot15", 1'b0, 1'b1, 4'd15);
      chk16("spot15_const", y0, 16'h8000);
      step("toggle_on", 1'b0, 1'b1, 4'b1010);
      chk16("toggle_on_const", y0, 16'h0400);
      step("toggle_off", 1'b0, 1'b0, 4'b1010);
      chk16("toggle_off_const", y0, 16'h0000);
      step("toggle_on2", 1'b0, 1'b1, 4'b1010);
      chk16("toggle_on2_const", y0, 16'h0400);
      step("pol_sel", 1'b0, 1'b1, 4'b0011);
      chk16("pol_sel_const", y1, 16'hFFF7);
      step("pol_dis", 1'b0, 1'b0, 4'b0011);
      chk16("pol_dis_const", y1, 16'hFFFF);
      step("pol_rst", 1'b1, 1'b1, 4'b0011);
      chk16("pol_rst_const", y1, 16'hFFFF);
      step("xa_dis", 1'b0, 1'b0, 4'bxxxx);
      step("prio_a", 1'b0, 1'b1, 4'd3);
      step("prio_b", 1'b0, 1'b1, 4'd4);
      step("prio_rst", 1'b1, 1'b1, 4'd5);
      step("prio_resume", 1'b0, 1'b1, 4'd6);
      chk16("prio_resume_const", y0, 16'h0040);
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 15) == 0);
         e = ($urandom_range(0, 3) != 0);
         a = 4'($urandom_range(0, 15));
         step("random", r, e, a);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
